// File: rtl/spi_slave_multimode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_multimode_pkg
// Purpose  : Shared definitions for the multi-mode SPI slave: SPI mode
//            encodings ({CPOL,CPHA}) and the transfer state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_slave_multimode_pkg;

    // SPI mode numbers encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Transfer state: IDLE outside a chip-select window, ACTIVE inside it
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_multimode_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_synchronizer
// Purpose  : Brings one asynchronous pin into system_clk with a STAGES-deep
//            flip-flop chain and flags rising/falling edges of the
//            synchronised level.
// Ports    : system_clk - clock
//            rst        - synchronous active-high reset
//            in         - asynchronous pin input
//            out        - synchronised level
//            rise, fall - single-cycle edge flags on the synchronised level
// Revision : 1.0 - initial release
// ============================================================================
module spi_pin_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic system_clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Chain and history reset to 0: a pin already low when reset releases
    // produces no falling edge, so a held-low ncs cannot start a transfer.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], in};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign out  = r_sync[STAGES-1];
    assign rise =  r_sync[STAGES-1] & ~r_prev;
    assign fall = ~r_sync[STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_multimode.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_multimode
// Purpose  : SPI slave supporting all four CPOL/CPHA modes, MSB/LSB-first
//            order and back-to-back words within one chip-select window.
//            All pins are synchronised into system_clk.
// Ports    : system_clk, rst            - clock, synchronous reset
//            pin_ncs/pin_clk/pin_mosi    - asynchronous SPI pins
//            pin_miso, pin_miso_en       - MISO data and pad enable
//            value_miso, value_miso_load - next TX word and capture pulse
//            value_mosi, value_valid     - last RX word and update pulse
//            cs_start, cs_stop           - chip-select window pulses
//            word_aborted                - window closed mid-word
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_multimode
    import spi_slave_multimode_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             system_clk,
    input  logic             rst,
    input  logic             pin_ncs,
    input  logic             pin_clk,
    input  logic             pin_mosi,
    output logic             pin_miso,
    output logic             pin_miso_en,
    input  logic [WIDTH-1:0] value_miso,
    output logic             value_miso_load,
    output logic [WIDTH-1:0] value_mosi,
    output logic             value_valid,
    output logic             cs_start,
    output logic             cs_stop,
    output logic             word_aborted
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    logic w_ncs, w_ncs_rise, w_ncs_fall;
    logic w_clk, w_clk_rise, w_clk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .system_clk (system_clk), .rst (rst), .in (pin_ncs),
        .out (w_ncs), .rise (w_ncs_rise), .fall (w_ncs_fall)
    );
    spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .system_clk (system_clk), .rst (rst), .in (pin_clk),
        .out (w_clk), .rise (w_clk_rise), .fall (w_clk_fall)
    );
    spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .system_clk (system_clk), .rst (rst), .in (pin_mosi),
        .out (w_mosi), .rise (w_mosi_rise), .fall (w_mosi_fall)
    );

    // Only edge flags of ncs/clk and the level of mosi are needed
    assign w_unused = &{1'b0, w_ncs, w_clk, w_mosi_rise, w_mosi_fall};

    // Leading edge leaves the idle level CPOL; trailing edge returns to it
    logic w_lead, w_trail, w_sample, w_shift;
    assign w_lead   = (CPOL != 0) ? w_clk_fall : w_clk_rise;
    assign w_trail  = (CPOL != 0) ? w_clk_rise : w_clk_fall;
    assign w_sample = (CPHA != 0) ? w_trail : w_lead;
    assign w_shift  = (CPHA != 0) ? w_lead  : w_trail;

    spi_state_t         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_tx, w_tx_nxt;
    logic [WIDTH-1:0]   r_rx, w_rx_nxt;
    logic [WIDTH-1:0]   r_word, w_word_nxt;
    logic               r_miso_en, w_miso_en_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_load, w_load_nxt;
    logic               r_start, w_start_nxt;
    logic               r_stop, w_stop_nxt;
    logic               r_abort, w_abort_nxt;
    logic [WIDTH-1:0]   w_rx_shifted, w_tx_shifted;

    assign w_rx_shifted = (LSB_FIRST != 0) ? {w_mosi, r_rx[WIDTH-1:1]}
                                           : {r_rx[WIDTH-2:0], w_mosi};
    assign w_tx_shifted = (LSB_FIRST != 0) ? {1'b0, r_tx[WIDTH-1:1]}
                                           : {r_tx[WIDTH-2:0], 1'b0};

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_word_nxt    = r_word;
        w_miso_en_nxt = r_miso_en;
        w_valid_nxt   = 1'b0;
        w_load_nxt    = 1'b0;
        w_start_nxt   = 1'b0;
        w_stop_nxt    = 1'b0;
        w_abort_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_ncs_fall) begin
                    w_state_nxt   = ACTIVE;
                    w_start_nxt   = 1'b1;
                    w_miso_en_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_rx_nxt      = '0;
                    // CPHA=0 must present the first bit before the first clock edge
                    if (CPHA == 0) begin
                        w_tx_nxt   = value_miso;
                        w_load_nxt = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (w_sample) begin
                    w_rx_nxt = w_rx_shifted;
                    if (r_cnt == c_last_bit) begin
                        w_cnt_nxt   = '0;
                        w_word_nxt  = w_rx_shifted;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                // A shift edge at a word boundary fetches the next word;
                // covers both the CPHA=1 first bit and the CPHA=0 wrap.
                if (w_shift) begin
                    if (r_cnt == '0) begin
                        w_tx_nxt   = value_miso;
                        w_load_nxt = 1'b1;
                    end else begin
                        w_tx_nxt = w_tx_shifted;
                    end
                end
                // Evaluated after the sample so a completing bit is not an abort
                if (w_ncs_rise) begin
                    w_state_nxt   = IDLE;
                    w_stop_nxt    = 1'b1;
                    w_abort_nxt   = (w_cnt_nxt != '0);
                    w_miso_en_nxt = 1'b0;
                    w_tx_nxt      = '0;
                    w_load_nxt    = 1'b0;
                    w_cnt_nxt     = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_word    <= '0;
            r_miso_en <= 1'b0;
            r_valid   <= 1'b0;
            r_load    <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_word    <= w_word_nxt;
            r_miso_en <= w_miso_en_nxt;
            r_valid   <= w_valid_nxt;
            r_load    <= w_load_nxt;
            r_start   <= w_start_nxt;
            r_stop    <= w_stop_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    // TX register is cleared on stop, so MISO returns to 0 with the enable
    assign pin_miso        = (LSB_FIRST != 0) ? r_tx[0] : r_tx[WIDTH-1];
    assign pin_miso_en     = r_miso_en;
    assign value_miso_load = r_load;
    assign value_mosi      = r_word;
    assign value_valid     = r_valid;
    assign cs_start        = r_start;
    assign cs_stop         = r_stop;
    assign word_aborted    = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_multimode.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_multimode
// Purpose  : Self-checking bench for spi_slave_multimode. Five instances:
//            modes 0..3 MSB-first and mode 0 LSB-first, each driven by a
//            bit-level SPI master model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_multimode;

    localparam int         N     = 5;
    localparam int         H     = 8;          // pin_clk half period, system_clk cycles
    localparam logic [4:0] c_cpol = 5'b01100;  // instance k uses bit k
    localparam logic [4:0] c_cpha = 5'b01010;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    ncs = '1;
    logic [N-1:0]    sclk = c_cpol;
    logic [N-1:0]    mosi = '0;
    logic [N-1:0]    miso, miso_en, load, valid, start, stop, abort;
    logic [N-1:0][7:0] vmiso;
    logic [N-1:0][7:0] vmosi;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave_multimode #(
            .WIDTH(8), .CPOL(int'(c_cpol[g])), .CPHA(int'(c_cpha[g])),
            .LSB_FIRST((g == 4) ? 1 : 0), .SYNC_STAGES(2)
        ) u_dut (
            .system_clk      (clk),
            .rst             (rst),
            .pin_ncs         (ncs[g]),
            .pin_clk         (sclk[g]),
            .pin_mosi        (mosi[g]),
            .pin_miso        (miso[g]),
            .pin_miso_en     (miso_en[g]),
            .value_miso      (vmiso[g]),
            .value_miso_load (load[g]),
            .value_mosi      (vmosi[g]),
            .value_valid     (valid[g]),
            .cs_start        (start[g]),
            .cs_stop         (stop[g]),
            .word_aborted    (abort[g])
        );
    end

    // ---------------- monitor: counts pulses, feeds value_miso ----------------
    int          cyc = 0;
    int          n_valid[N], n_load[N], n_start[N], n_stop[N], n_abort[N];
    int          last_valid_cyc[N], last_stop_cyc[N];
    logic [7:0]  got[N][8];
    logic [31:0] cur_tab = '0;   // word i at [31-8*i -: 8]
    int          ld_base[N];

    initial begin
        for (int k = 0; k < N; k++) begin
            n_valid[k] = 0; n_load[k] = 0; n_start[k] = 0; n_stop[k] = 0;
            n_abort[k] = 0; last_valid_cyc[k] = -1; last_stop_cyc[k] = -2;
        end
        vmiso = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < N; k++) begin
                int idx;
                if (valid[k]) begin
                    got[k][n_valid[k] % 8] = vmosi[k];
                    n_valid[k]++;
                    last_valid_cyc[k] = cyc;
                end
                if (load[k])  n_load[k]++;
                if (start[k]) n_start[k]++;
                if (stop[k])  begin n_stop[k]++; last_stop_cyc[k] = cyc; end
                if (abort[k]) n_abort[k]++;
                idx = n_load[k] - ld_base[k];
                if (idx > 3) idx = 3;
                if (idx < 0) idx = 0;
                vmiso[k] = cur_tab[31 - 8*idx -: 8];
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int s_valid, s_load, s_start, s_stop, s_abort;

    task automatic snap(input int k, input logic [31:0] tab);
        s_valid = n_valid[k]; s_load = n_load[k]; s_start = n_start[k];
        s_stop = n_stop[k]; s_abort = n_abort[k];
        ld_base[k] = n_load[k];
        cur_tab = tab;
        wait_cyc(2);
    endtask

    // ---------------- SPI master model ----------------
    task automatic cs_low(input int k);
        ncs[k] = 1'b0;
        wait_cyc(H);
    endtask

    task automatic cs_high(input int k);
        wait_cyc(H);
        ncs[k] = 1'b1;
        wait_cyc(2*H);
    endtask

    task automatic send_bit(input int k, input logic b, output logic mb);
        if (c_cpha[k] == 1'b0) begin
            mosi[k] = b;
            wait_cyc(H);
            mb = miso[k];
            sclk[k] = ~c_cpol[k];
            wait_cyc(H);
            sclk[k] = c_cpol[k];
        end else begin
            sclk[k] = ~c_cpol[k];
            mosi[k] = b;
            wait_cyc(H);
            mb = miso[k];
            sclk[k] = c_cpol[k];
            wait_cyc(H);
        end
    endtask

    // Sends bits[nbits-1] first; rx collects MISO bits in arrival order
    task automatic xfer(input int k, input int nbits, input logic [31:0] bits,
                        output logic [31:0] rx);
        logic mb;
        rx = '0;
        cs_low(k);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(k, bits[i], mb);
            rx = {rx[30:0], mb};
        end
        cs_high(k);
    endtask

    typedef struct {
        int          k;
        int          nbits;
        logic [31:0] bits;
        logic [31:0] tab;
        int          n_words;
        logic [31:0] exp_words;
        logic [31:0] exp_rx;
        int          exp_load;
        int          exp_abort;
        logic [7:0]  exp_vmosi;
    } vec_t;

    task automatic run_vec(input vec_t v, input int id);
        logic [31:0] rx;
        string       p;
        p = $sformatf("v%0d", id);
        snap(v.k, v.tab);
        xfer(v.k, v.nbits, v.bits, rx);
        chk({p, " valid_count"}, 32'(n_valid[v.k] - s_valid), 32'(v.n_words));
        chk({p, " load_count"},  32'(n_load[v.k]  - s_load),  32'(v.exp_load));
        chk({p, " cs_start"},    32'(n_start[v.k] - s_start), 32'd1);
        chk({p, " cs_stop"},     32'(n_stop[v.k]  - s_stop),  32'd1);
        chk({p, " aborted"},     32'(n_abort[v.k] - s_abort), 32'(v.exp_abort));
        chk({p, " master_rx"},   rx, v.exp_rx);
        chk({p, " value_mosi"},  32'(vmosi[v.k]), 32'(v.exp_vmosi));
        for (int i = 0; i < v.n_words; i++)
            chk($sformatf("%s word%0d", p, i), 32'(got[v.k][(s_valid + i) % 8]),
                32'(v.exp_words[31 - 8*i -: 8]));
        chk({p, " miso_en_off"}, 32'(miso_en[v.k]), 32'd0);
    endtask

    vec_t vecs[6];

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rx;
        logic        mb;
        vec_t        vr;

        vecs[0] = '{0,  8, 32'hA5,     32'h3C000000, 1, 32'hA5000000, 32'h3C,     2, 0, 8'hA5};
        vecs[1] = '{1, 24, 32'h0180FF, 32'h11223300, 3, 32'h0180FF00, 32'h112233, 3, 0, 8'hFF};
        vecs[2] = '{2, 24, 32'h0180FF, 32'h11223300, 3, 32'h0180FF00, 32'h112233, 4, 0, 8'hFF};
        vecs[3] = '{3, 24, 32'h0180FF, 32'h11223300, 3, 32'h0180FF00, 32'h112233, 3, 0, 8'hFF};
        vecs[4] = '{4,  8, 32'h80,     32'h01000000, 1, 32'h01000000, 32'h80,     2, 0, 8'h01};
        vecs[5] = '{0,  5, 32'h16,     32'h3C000000, 0, 32'h00000000, 32'h07,     1, 1, 8'hA5};

        // reset state, sampled while rst is held
        wait_cyc(4);
        for (int k = 0; k < N; k++)
            chk($sformatf("reset_outputs%0d", k),
                {19'd0, miso[k], miso_en[k], vmosi[k], valid[k], load[k], start[k], stop[k], abort[k]},
                32'd0);
        rst = 1'b0;
        wait_cyc(10);
        for (int k = 0; k < N; k++)
            chk($sformatf("post_reset_quiet%0d", k),
                32'(n_valid[k] + n_load[k] + n_start[k] + n_stop[k] + n_abort[k]), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // reset in the middle of a word with ncs held low afterwards
        snap(0, 32'h77000000);
        cs_low(0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, mb);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        chk("rst_mid miso_en", 32'(miso_en[0]), 32'd0);
        chk("rst_mid value_mosi", 32'(vmosi[0]), 32'd0);
        for (int i = 0; i < 8; i++) send_bit(0, 1'b1, mb);
        cs_high(0);
        chk("rst_mid no_valid", 32'(n_valid[0] - s_valid), 32'd0);
        chk("rst_mid no_stop", 32'(n_stop[0] - s_stop), 32'd0);
        vr = '{0, 8, 32'h5A, 32'h96000000, 1, 32'h5A000000, 32'h96, 2, 0, 8'h5A};
        run_vec(vr, 6);

        // ncs rises together with the 8th sample edge (mode 0)
        snap(0, 32'h00000000);
        cs_low(0);
        rx = 32'hC3;
        for (int i = 7; i >= 1; i--) send_bit(0, rx[i], mb);
        mosi[0] = rx[0];
        wait_cyc(H);
        sclk[0] = 1'b1;
        ncs[0]  = 1'b1;
        wait_cyc(H);
        sclk[0] = 1'b0;
        wait_cyc(2*H);
        chk("edge valid_count", 32'(n_valid[0] - s_valid), 32'd1);
        chk("edge stop_count", 32'(n_stop[0] - s_stop), 32'd1);
        chk("edge same_cycle", 32'(last_valid_cyc[0]), 32'(last_stop_cyc[0]));
        chk("edge no_abort", 32'(n_abort[0] - s_abort), 32'd0);
        chk("edge value_mosi", 32'(vmosi[0]), 32'hC3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
